// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM states and averaging constants.
package period_meter_pkg;

  typedef enum logic [1:0] {
    ST_ARM,
    ST_COUNT,
    ST_STALL
  } pm_state_e;

  // Depth of the sliding averaging window and its log2.
  localparam int unsigned AVG_DEPTH = 4;
  localparam int unsigned AVG_LOG2  = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Input synchroniser plus history flop with a rising-edge pulse output.
// The rise output is combinational from flops, so it is valid for the
// cycle in which the synchronised level first reads 1.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the asynchronous input through the synchroniser, then keep one cycle of history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/period_meter.sv
// Measures the rise-to-rise period of a slow asynchronous input in clk cycles.
// Optional build macro PERIOD_METER_AVG_EN: report a 4-period sliding average
// instead of each raw period.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             edge_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] raw_d;
  logic [CNT_W-1:0] period_q;
  logic             edge_q, edge_d;
  logic             valid_q;
  logic             load_raw;
  logic             rise;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sig_in),
    .rise (rise)
  );

  // Next-state, counter and raw-period logic for the ARM/COUNT/STALL machine.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edge_d   = 1'b0;
    load_raw = 1'b0;
    // counter+1 saturated: an edge on the saturation cycle reports the maximum
    raw_d    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    unique case (state_q)
      ST_ARM, ST_STALL: begin
        if (rise) begin
          edge_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (rise) begin
          edge_d   = 1'b1;
          load_raw = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_STALL;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  // State, counter and edge pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARM;
      cnt_q   <= '0;
      edge_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
    end
  end

  // Timeout rises on the saturation cycle itself unless an edge arrives then.
  assign timeout_o = (state_q == ST_STALL) ||
                     ((state_q == ST_COUNT) && (cnt_q == CNT_MAX) && !rise);

`ifdef PERIOD_METER_AVG_EN

  localparam logic [AVG_LOG2:0] FILL_ONE  = (AVG_LOG2+1)'(1);
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2+1)'(AVG_DEPTH);
  localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2+1)'(AVG_DEPTH - 1);

  logic [CNT_W-1:0]          hist_q [AVG_DEPTH];
  logic [CNT_W+AVG_LOG2-1:0] sum_q, sum_next;
  logic [AVG_LOG2:0]         fill_q;
  logic                      stall_enter;

  assign stall_enter = (state_q == ST_COUNT) && (state_d == ST_STALL);

  // Emptied slots hold zero, so subtracting the oldest entry is correct while filling.
  assign sum_next = sum_q + {{AVG_LOG2{1'b0}}, raw_d}
                          - {{AVG_LOG2{1'b0}}, hist_q[AVG_DEPTH-1]};

  // Sliding window of measured periods; reports the mean once the window is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      period_q <= '0;
      sum_q    <= '0;
      fill_q   <= '0;
      for (int unsigned i = 0; i < AVG_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      if (stall_enter) begin
        sum_q  <= '0;
        fill_q <= '0;
        for (int unsigned i = 0; i < AVG_DEPTH; i++) hist_q[i] <= '0;
      end else if (load_raw) begin
        hist_q[0] <= raw_d;
        for (int unsigned i = 1; i < AVG_DEPTH; i++) hist_q[i] <= hist_q[i-1];
        sum_q <= sum_next;
        if (fill_q != FILL_FULL) fill_q <= fill_q + FILL_ONE;
        if (fill_q >= FILL_LAST) begin
          valid_q  <= 1'b1;
          period_q <= sum_next[AVG_LOG2 +: CNT_W];
        end
      end
    end
  end

`else

  // Raw period register: loads on every measured period.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      period_q <= '0;
    end else begin
      valid_q <= load_raw;
      if (load_raw) period_q <= raw_d;
    end
  end

`endif

  assign edge_o         = edge_q;
  assign period_o       = period_q;
  assign period_valid_o = valid_q;

endmodule

// File: tb/tb_period_meter.sv
// Randomised self-checking bench for period_meter: a wide instance (a) and an
// 8-bit instance (b) for timeout and saturation boundaries. Expected outputs
// come from a rise-time / gap model built from sampled sig_in values.
`timescale 1ns/1ps
module tb_period_meter;

  localparam int S    = 2;
  localparam int CW_A = 24;
  localparam int CW_B = 8;
  localparam int MAXC = 40000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1;
  logic sig_a = 1'b0, sig_b = 1'b0;

  logic            edge_a, valid_a, tmo_a;
  logic [CW_A-1:0] per_a;
  logic            edge_b, valid_b, tmo_b;
  logic [CW_B-1:0] per_b;

  period_meter #(.CNT_W(CW_A), .SYNC_STAGES(S)) dut_a (
    .clk(clk), .rst(rst_a), .sig_in(sig_a), .edge_o(edge_a),
    .period_o(per_a), .period_valid_o(valid_a), .timeout_o(tmo_a)
  );

  period_meter #(.CNT_W(CW_B), .SYNC_STAGES(S)) dut_b (
    .clk(clk), .rst(rst_b), .sig_in(sig_b), .edge_o(edge_b),
    .period_o(per_b), .period_valid_o(valid_b), .timeout_o(tmo_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // samp[ch][k] / rsts[ch][k]: sig_in and rst as seen by posedge number k.
  bit     samp [2][0:MAXC];
  bit     rsts [2][0:MAXC];
  int     cyc = 0;
  bit     started [2];
  bit     armed   [2];
  int     last    [2];
  longint per_q   [2];
  longint win     [2][4];
  int     fill    [2];

  function automatic bit rise_at(input int ch, input int k);
    if (k < 1) return 1'b0;
    return samp[ch][k] && !samp[ch][k-1];
  endfunction

  bit          ee, ev, et, rn;
  longint      mx, p, gap, sum;
  logic [63:0] oe, ov, ot, op;
  string       nm;

  initial begin
    #1;
    samp[0][1] = sig_a; rsts[0][1] = rst_a;
    samp[1][1] = sig_b; rsts[1][1] = rst_b;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc >= MAXC - 2) begin
        $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cyc, MAXC - 2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "cycle budget exhausted");
      end
      // inputs change just after posedge, so the current value is what the next posedge sees
      samp[0][cyc+1] = sig_a; rsts[0][cyc+1] = rst_a;
      samp[1][cyc+1] = sig_b; rsts[1][cyc+1] = rst_b;
      for (int ch = 0; ch < 2; ch++) begin
        mx = (ch == 0) ? ((64'd1 << CW_A) - 1) : ((64'd1 << CW_B) - 1);
        ev = 1'b0;
        ee = 1'b0;
        et = 1'b0;
        if (rsts[ch][cyc]) begin
          started[ch] = 1'b1;
          armed[ch]   = 1'b1;
          per_q[ch]   = 0;
          fill[ch]    = 0;
        end else begin
          // a rise first sampled at posedge k shows on edge_o after posedge k+S
          ee = rise_at(ch, cyc - S);
          rn = rise_at(ch, cyc - S + 1);
          if (ee) begin
            gap = cyc - last[ch];
            if (!armed[ch] && gap <= mx + 1) begin
              p = (gap > mx) ? mx : gap;
`ifdef PERIOD_METER_AVG_EN
              if (fill[ch] == 4) begin
                for (int i = 0; i < 3; i++) win[ch][i] = win[ch][i+1];
                win[ch][3] = p;
              end else begin
                win[ch][fill[ch]] = p;
                fill[ch]++;
              end
              if (fill[ch] == 4) begin
                sum = 0;
                for (int i = 0; i < 4; i++) sum += win[ch][i];
                ev = 1'b1;
                per_q[ch] = sum / 4;
              end
`else
              ev = 1'b1;
              per_q[ch] = p;
`endif
            end else begin
              fill[ch] = 0;
            end
            armed[ch] = 1'b0;
            last[ch]  = cyc;
          end
          gap = cyc - last[ch];
          et = !armed[ch] && ((gap > mx) || (gap == mx && !rn));
        end
        if (started[ch]) begin
          nm = (ch == 0) ? "a" : "b";
          oe = (ch == 0) ? 64'(edge_a)  : 64'(edge_b);
          ov = (ch == 0) ? 64'(valid_a) : 64'(valid_b);
          ot = (ch == 0) ? 64'(tmo_a)   : 64'(tmo_b);
          op = (ch == 0) ? 64'(per_a)   : 64'(per_b);
          check({nm, ".edge"},    oe, 64'(ee));
          check({nm, ".valid"},   ov, 64'(ev));
          check({nm, ".timeout"}, ot, 64'(et));
          check({nm, ".period"},  op, 64'(per_q[ch]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_sig(input int ch, input logic v);
    if (ch == 0) sig_a = v;
    else         sig_b = v;
  endtask

  task automatic wave(input int ch, input int hi, input int lo);
    set_sig(ch, 1'b1);
    step(hi);
    set_sig(ch, 1'b0);
    step(lo);
  endtask

  int gaps_b [5] = '{254, 255, 256, 257, 256};

  initial begin
    step(4);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step(5);

    // instance a: nominal 100-cycle square wave, minimum period, /2048 divider
    repeat (5)  wave(0, 50, 50);
    repeat (12) wave(0, 1, 1);
    repeat (3)  wave(0, 1024, 1024);

    // reset 40 cycles into a 100-cycle period (input low at that point)
    set_sig(0, 1'b1); step(30);
    set_sig(0, 1'b0); step(10);
    rst_a = 1'b1; step(2);
    rst_a = 1'b0; step(58);
    repeat (3) wave(0, 30, 70);

    // fresh window, then periods 100, 104, 96, 100, 120
    rst_a = 1'b1; step(2);
    rst_a = 1'b0; step(10);
    wave(0, 50, 50);
    wave(0, 52, 52);
    wave(0, 48, 48);
    wave(0, 50, 50);
    wave(0, 60, 60);
    set_sig(0, 1'b1); step(5);
    set_sig(0, 1'b0); step(20);

    repeat (40) wave(0, int'($urandom_range(1, 60)), int'($urandom_range(1, 60)));
    step(10);

    // instance b: stuck high after one edge -> timeout, recovery, then saturation boundaries
    set_sig(1, 1'b1); step(400);
    set_sig(1, 1'b0); step(3);
    repeat (3) wave(1, 60, 40);
    foreach (gaps_b[i]) wave(1, 100, gaps_b[i] - 100);
    repeat (30) wave(1, int'($urandom_range(1, 200)), int'($urandom_range(1, 200)));
    step(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
